// File: rtl/axis_mac_tx_queue_pkg.sv
// tx_queue_pkg: FSM state types and tstrb encode/decode helpers shared by
// the AXIS-to-MAC transmit queue and its packet FIFO.
package tx_queue_pkg;

    // Encoding is sized for the widest legal bus (256 bits, 32 bytes).
    localparam int MAX_BYTES  = 32;
    localparam int KEEP_ENC_W = 5;

    typedef enum logic [1:0] {
        MAC_IDLE,
        MAC_WAIT_ACK,
        MAC_SEND,
        MAC_IFG
    } mac_state_e;

    typedef enum logic {
        ENQ_FIRST,
        ENQ_BODY
    } enq_state_e;

    // cnt holds popcount-1; inv marks an all-zero or non-prefix strobe.
    typedef struct packed {
        logic                  inv;
        logic [KEEP_ENC_W-1:0] cnt;
    } keep_enc_t;

    function automatic keep_enc_t strb_encode(
        input logic [MAX_BYTES-1:0] strb,
        input int                   nbytes
    );
        keep_enc_t          enc;
        logic [MAX_BYTES:0] m;
        logic [MAX_BYTES:0] m1;
        int                 n;
        m = '0;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && strb[i]) begin
                m[i] = 1'b1;
                n++;
            end
        end
        // A prefix mask plus one has no bit in common with the mask.
        m1      = m + (MAX_BYTES+1)'(1);
        enc.inv = (n == 0) || ((m & m1) != '0);
        enc.cnt = (n == 0) ? '0 : KEEP_ENC_W'(n - 1);
        return enc;
    endfunction

    function automatic logic [MAX_BYTES-1:0] strb_decode(
        input keep_enc_t enc,
        input int        nbytes
    );
        logic [MAX_BYTES-1:0] d;
        d = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            d[i] = !enc.inv && (i < nbytes) && (i <= int'(enc.cnt));
        end
        return d;
    endfunction

endpackage

// File: rtl/axis_mac_tx_queue_sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock first-word-fall-through RAM FIFO with a
// commit pointer that the write pointer can be rewound to.
// Ports: clk, reset (sync, active high); wr_en/wr_data write a word;
// commit snapshots the write pointer, rewind restores it; rd_en pops,
// rd_data shows the head word; level counts stored words; almost_full
// means fewer than two free words.
module sync_pkt_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  commit,
    input  logic                  rewind,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full
);

    localparam logic [DEPTH_LOG2:0] ONE    = 1;
    localparam logic [DEPTH_LOG2:0] AF_LVL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2 - 2);

    logic [WIDTH-1:0]    mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] cmt_ptr_q, cmt_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (rewind) begin
            wr_ptr_d = cmt_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (commit) begin
            cmt_ptr_d = wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign level       = wr_ptr_q - rd_ptr_q;
    assign almost_full = level > AF_LVL;

endmodule

// File: rtl/axis_mac_tx_queue.sv
// axis_mac_tx_queue: store-and-forward AXIS to MAC TX queue; a packet is
// offered to the MAC only once its last word is stored.
// Ports: AXIS slave (tdata/tstrb/tuser/tvalid/tlast/tready), MAC client
// (tx_data/tx_data_valid/tx_start/tx_ack), stat strobes, fifo_level.
// Build option TX_OVERSIZE_DROP_EN discards packets above MAX_PKT_WORDS.
module axis_mac_tx_queue
    import tx_queue_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int TUSER_WIDTH   = 128,
    parameter int DEPTH_LOG2    = 9,
    parameter int PKT_CNT_LOG2  = 6,
    parameter int IFG_CYCLES    = 1,
    parameter int MAX_PKT_WORDS = 190
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   tdata,
    input  logic [DATA_WIDTH/8-1:0] tstrb,
    input  logic [TUSER_WIDTH-1:0]  tuser,
    input  logic                    tvalid,
    input  logic                    tlast,
    output logic                    tready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic [DATA_WIDTH/8-1:0] tx_data_valid,
    output logic                    tx_start,
    input  logic                    tx_ack,
    output logic                    tx_pkts_enqueued,
    output logic [15:0]             tx_bytes_enqueued,
    output logic                    tx_pkts_dequeued,
    output logic                    tx_drop_pkt,
    output logic [DEPTH_LOG2:0]     fifo_level
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int FW = DATA_WIDTH + KEEP_ENC_W + 2;
    localparam int CW = PKT_CNT_LOG2 + 1;
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef logic [NB-1:0] keep_t;

    logic [FW-1:0]           wr_word;
    logic [FW-1:0]           rd_word;
    logic                    fifo_af;
    logic                    accept;
    logic                    wr_en;
    logic                    drop;
    logic                    commit_d, commit_q;
    logic [PKT_CNT_LOG2-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CW-1:0]           pkt_pend;
    enq_state_e              enq_q, enq_d;
    logic                    enq_first;
    mac_state_e              mac_q, mac_d;
    logic [IW-1:0]           ifg_q, ifg_d;
    logic                    pop;
    logic                    hd_eop;
    keep_enc_t               hd_enc;
    logic [DATA_WIDTH-1:0]   hd_data;
    logic                    unused_tuser;

    assign unused_tuser = ^tuser[TUSER_WIDTH-1:16];

    // A commit still in flight already counts against packet capacity.
    assign pkt_pend = CW'(pkt_cnt_q) + CW'(commit_q);
    assign tready   = !reset && !fifo_af &&
                      (pkt_pend < CW'(2**PKT_CNT_LOG2 - 1));
    assign accept   = tvalid && tready;
    assign wr_word  = {tlast, strb_encode(MAX_BYTES'(tstrb), NB), tdata};

`ifdef TX_OVERSIZE_DROP_EN
    localparam int WW = $clog2(MAX_PKT_WORDS + 1);

    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          oversize;

    // The counter saturates at the threshold; beats past it are swallowed.
    assign oversize = (wcnt_q == WW'(MAX_PKT_WORDS));
    assign wr_en    = accept && !oversize;
    assign drop     = accept && tlast && oversize;

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept) begin
            if (tlast) begin
                wcnt_d = '0;
            end else if (!oversize) begin
                wcnt_d = wcnt_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic [15:0] unused_max;

    assign unused_max = 16'(MAX_PKT_WORDS);
    assign wr_en      = accept;
    assign drop       = 1'b0;
`endif

    assign tx_drop_pkt = drop;
    assign commit_d    = accept && tlast && !drop;

    sync_pkt_fifo #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_word),
        .commit      (commit_q),
        .rewind      (drop),
        .rd_en       (pop),
        .rd_data     (rd_word),
        .level       (fifo_level),
        .almost_full (fifo_af)
    );

    assign {hd_eop, hd_enc, hd_data} = rd_word;

    always_comb begin
        unique case ({commit_q, tx_start})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PKT_CNT_LOG2'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - PKT_CNT_LOG2'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q  <= 1'b0;
            pkt_cnt_q <= '0;
            enq_q     <= ENQ_FIRST;
            mac_q     <= MAC_IDLE;
            ifg_q     <= '0;
        end else begin
            commit_q  <= commit_d;
            pkt_cnt_q <= pkt_cnt_d;
            enq_q     <= enq_d;
            mac_q     <= mac_d;
            ifg_q     <= ifg_d;
        end
    end

    always_comb begin
        enq_d = enq_q;
        unique case (enq_q)
            ENQ_FIRST: if (accept && !tlast) enq_d = ENQ_BODY;
            ENQ_BODY:  if (accept && tlast)  enq_d = ENQ_FIRST;
        endcase
    end

    always_comb begin
        enq_first         = (enq_q == ENQ_FIRST) && accept;
        tx_pkts_enqueued  = enq_first;
        tx_bytes_enqueued = enq_first ? tuser[15:0] : 16'd0;
    end

    always_comb begin
        mac_d = mac_q;
        ifg_d = '0;
        unique case (mac_q)
            MAC_IDLE: begin
                if (pkt_cnt_q != '0) mac_d = MAC_WAIT_ACK;
            end
            MAC_WAIT_ACK, MAC_SEND: begin
                if (pop) begin
                    if (hd_eop) begin
                        mac_d = (IFG_CYCLES == 0) ? MAC_IDLE : MAC_IFG;
                    end else begin
                        mac_d = MAC_SEND;
                    end
                end
            end
            MAC_IFG: begin
                ifg_d = ifg_q + IW'(1);
                if (ifg_q == IW'(IFG_CYCLES - 1)) begin
                    mac_d = MAC_IDLE;
                    ifg_d = '0;
                end
            end
            default: mac_d = MAC_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (mac_q == MAC_IDLE) && (pkt_cnt_q != '0);
        pop      = ((mac_q == MAC_WAIT_ACK) && tx_ack) ||
                   (mac_q == MAC_SEND);
        tx_data  = ((mac_q == MAC_WAIT_ACK) || (mac_q == MAC_SEND)) ?
                   hd_data : '0;
        tx_data_valid    = pop ? keep_t'(strb_decode(hd_enc, NB)) : '0;
        tx_pkts_dequeued = pop && hd_eop;
    end

endmodule
